// File: rtl/ssp_slave.sv
// ssp_slave: SPI mode-0 responder that oversamples the SSP pins in the CLK domain.
// It shifts one DATA_W-bit word per frame, or several back-to-back words while
// chip select stays low.
//
// Ports:
//   CLK, RST                        system clock, synchronous active-high reset
//   ssp_clk_i, ssp_en_i, ssp_mosi_i asynchronous SPI pins from the master (en active-low)
//   ssp_miso_o, ssp_miso_oe         slave-out data and its output enable
//   tx_data, tx_valid, tx_ready     one-entry transmit holding register (valid/ready)
//   rx_data, rx_valid               last completed word and its one-cycle update strobe
//   tx_underrun                     pulse when TX_IDLE was loaded because the holding reg was empty
//   busy                            frame in progress (synchronised chip select asserted)
module ssp_slave #(
    parameter int unsigned       DATA_W    = 8,
    parameter bit                MSB_FIRST = 1'b1,
    parameter logic [DATA_W-1:0] TX_IDLE   = DATA_W'(8'hFF)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ssp_clk_i,
    input  logic              ssp_en_i,
    input  logic              ssp_mosi_i,
    output logic              ssp_miso_o,
    output logic              ssp_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t             state, state_nxt;
    logic [2:0]         sclk_sync, cs_sync;
    logic [1:0]         mosi_sync;
    logic [DATA_W-1:0]  shift_tx, shift_tx_nxt;
    logic [DATA_W-1:0]  shift_rx, shift_rx_nxt;
    logic [DATA_W-1:0]  hold_data, hold_data_nxt;
    logic [DATA_W-1:0]  rx_data_nxt;
    logic [CNT_W-1:0]   bitcnt, bitcnt_nxt;
    logic               skip_fall, skip_fall_nxt;
    logic               tx_ready_nxt, rx_valid_nxt, tx_underrun_nxt, busy_nxt, miso_nxt;
    logic               load;
    logic               sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_bit;

    // Stage 2 vs stage 3 gives the edge strobes; MOSI stage 2 lines up with SCLK stage 2.
    // CS synchroniser clears to "selected" so a reset with CS still low sees no cs_fall.
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign mosi_bit  = mosi_sync[1];

    assign ssp_miso_oe = busy;

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            sclk_sync   <= '0;
            cs_sync     <= '0;
            mosi_sync   <= '0;
            state       <= IDLE;
            shift_tx    <= '0;
            shift_rx    <= '0;
            hold_data   <= '0;
            bitcnt      <= '0;
            skip_fall   <= 1'b0;
            tx_ready    <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            busy        <= 1'b0;
            ssp_miso_o  <= 1'b1;
        end else begin
            sclk_sync   <= {sclk_sync[1:0], ssp_clk_i};
            cs_sync     <= {cs_sync[1:0], ssp_en_i};
            mosi_sync   <= {mosi_sync[0], ssp_mosi_i};
            state       <= state_nxt;
            shift_tx    <= shift_tx_nxt;
            shift_rx    <= shift_rx_nxt;
            hold_data   <= hold_data_nxt;
            bitcnt      <= bitcnt_nxt;
            skip_fall   <= skip_fall_nxt;
            tx_ready    <= tx_ready_nxt;
            rx_data     <= rx_data_nxt;
            rx_valid    <= rx_valid_nxt;
            tx_underrun <= tx_underrun_nxt;
            busy        <= busy_nxt;
            ssp_miso_o  <= miso_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt       = state;
        shift_tx_nxt    = shift_tx;
        shift_rx_nxt    = shift_rx;
        hold_data_nxt   = hold_data;
        bitcnt_nxt      = bitcnt;
        skip_fall_nxt   = skip_fall;
        tx_ready_nxt    = tx_ready;
        rx_data_nxt     = rx_data;
        rx_valid_nxt    = 1'b0;
        tx_underrun_nxt = 1'b0;
        load            = 1'b0;

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    load          = 1'b1;
                    bitcnt_nxt    = '0;
                    skip_fall_nxt = 1'b0;
                    state_nxt     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sclk_rise) begin
                    shift_rx_nxt = MSB_FIRST ? {shift_rx[DATA_W-2:0], mosi_bit}
                                             : {mosi_bit, shift_rx[DATA_W-1:1]};
                    if (bitcnt == CNT_W'(DATA_W - 1)) begin
                        // Word done: publish it and reload so the next word follows gaplessly
                        rx_data_nxt   = shift_rx_nxt;
                        rx_valid_nxt  = 1'b1;
                        bitcnt_nxt    = '0;
                        load          = 1'b1;
                        skip_fall_nxt = 1'b1;
                    end else begin
                        bitcnt_nxt = bitcnt + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    // The fall right after a reload must keep the fresh first bit on MISO
                    if (skip_fall) begin
                        skip_fall_nxt = 1'b0;
                    end else begin
                        shift_tx_nxt = MSB_FIRST ? {shift_tx[DATA_W-2:0], 1'b1}
                                                 : {1'b1, shift_tx[DATA_W-1:1]};
                    end
                end
                if (cs_rise) begin
                    state_nxt  = IDLE;
                    bitcnt_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Load uses the holding-register state before any same-cycle write
        if (load) begin
            if (!tx_ready) begin
                shift_tx_nxt = hold_data;
                tx_ready_nxt = 1'b1;
            end else begin
                shift_tx_nxt    = TX_IDLE;
                tx_underrun_nxt = 1'b1;
            end
        end

        if (tx_valid && tx_ready) begin
            hold_data_nxt = tx_data;
            tx_ready_nxt  = 1'b0;
        end

        busy_nxt = (state_nxt == ACTIVE);
        miso_nxt = busy_nxt ? (MSB_FIRST ? shift_tx_nxt[DATA_W-1] : shift_tx_nxt[0]) : 1'b1;
    end

endmodule

// File: tb/tb_ssp_slave.sv
// tb_ssp_slave: directed SPI mode-0 master driving two ssp_slave instances that share
// the SPI pins. Instance a is MSB-first and instance b is LSB-first.
module tb_ssp_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk, cs_n, mosi;
    logic [7:0] tx_data_a, tx_data_b, rx_data_a, rx_data_b;
    logic       tx_valid_a, tx_valid_b, tx_ready_a, tx_ready_b;
    logic       rx_valid_a, rx_valid_b, unr_pulse_a, unr_pulse_b;
    logic       miso_a, miso_b, oe_a, oe_b, busy_a, busy_b;

    int         nvec = 0;
    int         nerr = 0;
    int         unr_a = 0;
    logic [7:0] rxq_a[$];
    logic [7:0] rxq_b[$];

    always #5 clk = ~clk;

    ssp_slave dut_a (
        .CLK(clk), .RST(rst),
        .ssp_clk_i(sclk), .ssp_en_i(cs_n), .ssp_mosi_i(mosi),
        .ssp_miso_o(miso_a), .ssp_miso_oe(oe_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .tx_underrun(unr_pulse_a), .busy(busy_a)
    );

    ssp_slave #(.MSB_FIRST(1'b0)) dut_b (
        .CLK(clk), .RST(rst),
        .ssp_clk_i(sclk), .ssp_en_i(cs_n), .ssp_mosi_i(mosi),
        .ssp_miso_o(miso_b), .ssp_miso_oe(oe_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .tx_underrun(unr_pulse_b), .busy(busy_b)
    );

    // Record every received word and underrun pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (rx_valid_a) rxq_a.push_back(rx_data_a);
        if (rx_valid_b) rxq_b.push_back(rx_data_b);
        if (unr_pulse_a) unr_a++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input bit sel_b, input logic [7:0] d);
        if (sel_b) begin
            tx_data_b = d; tx_valid_b = 1'b1; tick(1); tx_valid_b = 1'b0;
        end else begin
            tx_data_a = d; tx_valid_a = 1'b1; tick(1); tx_valid_a = 1'b0;
        end
    endtask

    // One SCLK period of 8 CLK: MOSI set at the fall, MISO sampled at the rise
    task automatic sck_bit(input logic mo, input bit lsb, output logic mi);
        mosi = mo;
        tick(4);
        sclk = 1'b1;
        mi = lsb ? miso_b : miso_a;
        tick(4);
        sclk = 1'b0;
    endtask

    task automatic shift_bits(input int nbits, input logic [15:0] mo, input bit lsb,
                              output logic [15:0] mi);
        logic b;
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            if (lsb) begin
                sck_bit(mo[i], 1'b1, b);
                mi[i] = b;
            end else begin
                sck_bit(mo[nbits-1-i], 1'b0, b);
                mi[nbits-1-i] = b;
            end
        end
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        tick(6);
    endtask

    task automatic cs_end();
        tick(4);
        cs_n = 1'b1;
        tick(8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] mi;
        int q0, u0;

        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_data_a = '0; tx_data_b = '0; tx_valid_a = 1'b0; tx_valid_b = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(3);
        check("rst_miso", miso_a, 1);
        check("rst_oe", oe_a, 0);
        check("rst_tx_ready", tx_ready_a, 1);
        check("rst_rx_data", rx_data_a, 0);
        check("rst_rx_valid", rx_valid_a, 0);
        check("rst_underrun", unr_a, 0);
        check("rst_busy", busy_a, 0);

        // Single byte, preloaded A5, master sends 3C
        preload(1'b0, 8'hA5);
        check("t1_ready_lo", tx_ready_a, 0);
        q0 = rxq_a.size(); u0 = unr_a;
        cs_start();
        check("t1_ready_hi", tx_ready_a, 1);
        check("t1_busy", busy_a, 1);
        check("t1_oe", oe_a, 1);
        check("t1_no_unr", unr_a - u0, 0);
        shift_bits(8, 16'h003C, 1'b0, mi);
        cs_end();
        check("t1_miso_word", mi, 16'h00A5);
        check("t1_rx_count", rxq_a.size() - q0, 1);
        check("t1_rx_data", rx_data_a, 8'h3C);
        check("t1_busy_end", busy_a, 0);
        check("t1_miso_idle", miso_a, 1);

        // Empty holding register
        q0 = rxq_a.size(); u0 = unr_a;
        cs_start();
        check("t2_unr_at_csfall", unr_a - u0, 1);
        shift_bits(8, 16'h0081, 1'b0, mi);
        cs_end();
        check("t2_miso_word", mi, 16'h00FF);
        check("t2_rx_count", rxq_a.size() - q0, 1);
        check("t2_rx_data", rx_data_a, 8'h81);

        // Back-to-back words in one frame
        preload(1'b0, 8'h11);
        q0 = rxq_a.size();
        cs_start();
        check("t3_ready_hi", tx_ready_a, 1);
        preload(1'b0, 8'h22);
        check("t3_ready_lo", tx_ready_a, 0);
        shift_bits(16, 16'hC35A, 1'b0, mi);
        cs_end();
        check("t3_miso_words", mi, 16'h1122);
        check("t3_rx_count", rxq_a.size() - q0, 2);
        check("t3_rx_first", rxq_a[q0], 8'hC3);
        check("t3_rx_second", rxq_a[q0+1], 8'h5A);

        // Abort after 5 bits, then a full frame
        q0 = rxq_a.size();
        cs_start();
        shift_bits(5, 16'h001F, 1'b0, mi);
        cs_end();
        check("t4_abort_no_rx", rxq_a.size() - q0, 0);
        check("t4_abort_hold", rx_data_a, 8'h5A);
        cs_start();
        shift_bits(8, 16'h0096, 1'b0, mi);
        cs_end();
        check("t4_rx_count", rxq_a.size() - q0, 1);
        check("t4_rx_data", rx_data_a, 8'h96);
        check("t4_miso_word", mi, 16'h00FF);

        // LSB-first instance
        preload(1'b1, 8'h80);
        q0 = rxq_b.size();
        cs_start();
        shift_bits(8, 16'h0001, 1'b1, mi);
        cs_end();
        check("t5_rx_data", rx_data_b, 8'h01);
        check("t5_rx_count", rxq_b.size() - q0, 1);
        check("t5_first_bit", mi[0], 0);
        check("t5_last_bit", mi[7], 1);
        check("t5_miso_word", mi, 16'h0080);

        // Reset after 3 bits with CS held low
        preload(1'b0, 8'h5A);
        cs_start();
        shift_bits(3, 16'h0005, 1'b0, mi);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_busy", busy_a, 0);
        check("t6_oe", oe_a, 0);
        check("t6_miso", miso_a, 1);
        check("t6_tx_ready", tx_ready_a, 1);
        check("t6_rx_data", rx_data_a, 0);
        q0 = rxq_a.size();
        shift_bits(5, 16'h001F, 1'b0, mi);
        check("t6_busy_rest", busy_a, 0);
        cs_end();
        check("t6_no_rx", rxq_a.size() - q0, 0);
        cs_start();
        shift_bits(8, 16'h00E7, 1'b0, mi);
        cs_end();
        check("t6_rx_count", rxq_a.size() - q0, 1);
        check("t6_rx_data", rx_data_a, 8'hE7);
        check("t6_miso_word", mi, 16'h00FF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ssp_slave.md
Name: ssp_slave

Overview:
- SPI-mode-0 responder: the far end of the CPU's SSP master port (ssp_en/ssp_clk/ssp_mosi/ssp_miso).
- Used as a loopback/peripheral target on board builds and as the bench model for the master.
- Oversamples the SPI pins in the system clock domain and shifts one DATA_W-bit word per frame.
- Exposes a one-entry transmit holding register and a received-word strobe to local logic.

Parameters:
- DATA_W, 8, bits per SPI word.
- MSB_FIRST, 1, 1 = MSB shifted first on both MOSI and MISO; 0 = LSB first.
- TX_IDLE, 8'hFF, word sent on MISO when the holding register is empty at load time.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- ssp_clk_i  in  1  SPI SCLK from master, asynchronous; CPOL=0.
- ssp_en_i  in  1  chip select from master, asynchronous, active-low.
- ssp_mosi_i  in  1  master-out data, asynchronous.
- ssp_miso_o  out  1  slave-out data.
- ssp_miso_oe  out  1  MISO output enable; high only while selected.
- tx_data  in  DATA_W  word to send in a later frame.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  holding register empty; transfer occurs when tx_valid && tx_ready.
- rx_data  out  DATA_W  last complete received word; held until the next word completes.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- tx_underrun  out  1  one-cycle pulse when TX_IDLE is loaded because the holding register was empty.
- busy  out  1  high while ssp_en is synchronously asserted.

Behaviour:
- Clocking: one clock (CLK); reset is synchronous and active-high (RST).
- Synchronizers:
  - ssp_clk_i, ssp_en_i and ssp_mosi_i each pass through 2 flops, plus a third flop for edge detection.
  - sclk_rise, sclk_fall, cs_fall and cs_rise are single-cycle strobes derived from stages 2/3.
  - Each strobe asserts 3 CLK after the pin edge.
  - Supported limit: SCLK period >= 8 CLK, with each level >= 4 CLK; behaviour above this rate is undefined.
- Reset values:
  - ssp_miso_o=1, ssp_miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0.
  - Holding register empty; FSM in IDLE; bit counter 0.
- FSM states and transitions:
  - IDLE: waits for cs_fall. On cs_fall: load shift_tx from the holding register, or TX_IDLE with a tx_underrun pulse if empty. Then bitcnt=0, busy=1, next state ACTIVE.
  - ACTIVE, on sclk_rise: shift the synchronized MOSI bit into shift_rx; bitcnt+1.
  - ACTIVE, on sclk_rise with bitcnt==DATA_W-1:
    - Next cycle: rx_data <= completed word, rx_valid=1 for exactly one cycle, bitcnt=0.
    - shift_tx reloads from the holding register (or TX_IDLE plus tx_underrun) so back-to-back words in one frame run without a gap.
  - ACTIVE, on sclk_fall: advance shift_tx by one bit, except on the fall that follows a reload.
  - ACTIVE, on cs_rise: return to IDLE; busy=0; discard any partial word (no rx_valid); bitcnt=0.
- MISO drive:
  - ssp_miso_o = current shift_tx bit (MSB or LSB per MSB_FIRST); the first bit is valid from the cs_fall strobe cycle.
  - ssp_miso_oe = busy.
  - ssp_miso_o=1 when idle.
- Holding register:
  - Written when tx_valid && tx_ready; tx_ready drops the next cycle.
  - Emptied when it is loaded into shift_tx; tx_ready rises the next cycle.
  - Writes while the register is full are ignored; the upstream side must wait for tx_ready.
- Simultaneous events:
  - A write in the same cycle as a load: the load takes the old (empty → TX_IDLE) state; the new word stays in the register.
  - cs_rise on the same cycle as the final sclk_rise: the word completes (rx_valid fires), then the FSM goes to IDLE.
  - cs_fall while in ACTIVE: impossible by construction; ignored.
- RST mid-frame:
  - All state is cleared and the holding register is dropped.
  - The FSM stays in IDLE until the next cs_fall, even if CS is still low; the remainder of that frame is ignored.

Test Plan:
- Single byte, MSB_FIRST=1: preload tx_data=8'hA5, master sends 8'h3C at SCLK=CLK/8 → rx_data=8'h3C with one rx_valid pulse; master samples 8'hA5; tx_ready re-asserts after cs_fall.
- Empty holding register: master sends 8'h81 with nothing preloaded → MISO carries 8'hFF; tx_underrun pulses once at cs_fall; rx_data=8'h81.
- Back-to-back words: preload 8'h11, then 8'h22 written after tx_ready rises; one CS frame of 16 clocks carrying 8'hC3,8'h5A → two rx_valid pulses with 8'hC3 then 8'h5A; master receives 8'h11 then 8'h22 with no gap bit.
- Abort: CS deasserted after 5 SCLK rising edges → no rx_valid; rx_data keeps its previous value; the next full frame receives correctly.
- MSB_FIRST=0: master sends LSB-first 8'h01, slave preloaded 8'h80 → rx_data=8'h01; first MISO bit 0, last 1.
- Reset mid-frame: assert RST for 1 cycle after 3 bits with CS held low → outputs return to reset values; no rx_valid; the following frame after a new cs_fall works normally.
